// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller family.
package ssd_pkg;

  localparam int unsigned SSD_RATE_W   = 16;
  localparam int unsigned SSD_BRIGHT_W = 4;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0000010;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/ssd_hex_dec.sv
// Combinational hex nibble to active-low seven-segment decoder.
module ssd_hex_dec
  import ssd_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for one hex digit
  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_n.sv
// Multiplexed seven-segment scan controller: programmable slot length,
// PWM brightness, leading-zero suppression and double-buffered frame data.
module ssd_scan_n
  import ssd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned RATE_W   = SSD_RATE_W,
  parameter int unsigned BRIGHT_W = SSD_BRIGHT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [RATE_W-1:0]     rate,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned      IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
  } frame_t;

  logic [RATE_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  frame_t              shadow_q, shadow_d;
  frame_t              active_q, active_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fd_q, fd_d;

  logic                tick, wrap;
  frame_t              in_frame;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank, suppressed, hi_zero, lit, dark;
  logic [DIGITS-1:0]   sel_anode;
  logic [6:0]          dec_seg;

  assign in_frame = '{data: data_in, dp: dp_in, blank: blank_in};

  // Slot counter, digit index, PWM counter and shadow/active buffer handover
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pwm_d     = pwm_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    tick      = en && (cnt_q >= rate);
    wrap      = tick && (idx_q == IDX_LAST);
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + RATE_W'(1);
      pwm_d = pwm_q + BRIGHT_W'(1);
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    // A load landing on the wrap bypasses the shadow so the very next
    // frame already shows it; otherwise it waits in shadow until the wrap.
    if (load && wrap) begin
      shadow_d  = in_frame;
      active_d  = in_frame;
      pending_d = 1'b0;
    end else begin
      if (wrap && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (load) begin
        shadow_d  = in_frame;
        pending_d = 1'b1;
      end
    end
  end

  // Select the current digit and evaluate leading-zero suppression,
  // scanning from the most significant nibble downwards
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    suppressed = 1'b0;
    sel_anode  = '1;
    hi_zero    = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      hi_zero = hi_zero && (active_q.data[4*(DIGITS-1-j) +: 4] == 4'h0);
      if (IDX_W'(DIGITS - 1 - j) == idx_q) begin
        cur_nib                 = active_q.data[4*(DIGITS-1-j) +: 4];
        cur_dp                  = active_q.dp[DIGITS-1-j];
        cur_blank               = active_q.blank[DIGITS-1-j];
        sel_anode[DIGITS-1-j]   = 1'b0;
        suppressed              = lz_en && (j != DIGITS - 1) && hi_zero;
      end
    end
  end

  ssd_hex_dec u_dec (
    .hex_i (cur_nib),
    .seg_o (dec_seg)
  );

  // Output pattern for the current slot, dark when any blanking source applies
  always_comb begin
    lit     = (bright == '1) || (pwm_q < bright);
    dark    = !en || cur_blank || suppressed || !lit;
    anode_d = '1;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    fd_d    = wrap;
    if (!dark) begin
      anode_d = sel_anode;
      seg_d   = dec_seg;
      dp_d    = ~cur_dp;
    end
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      pwm_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      anode_q   <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pwm_q     <= pwm_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_n.sv
// Self-checking bench for ssd_scan_n (4 digits, 16-bit rate, 4-bit brightness).
module tb_ssd_scan_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] rate = '0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ssd_scan_n #(.DIGITS(4), .RATE_W(16), .BRIGHT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rate       (rate),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .load       (load),
    .bright     (bright),
    .anode      (anode),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // Glyph table straight from the display definition
  logic [6:0] segtab [16];
  initial begin
    segtab[0]  = 7'b0000001; segtab[1]  = 7'b1001111;
    segtab[2]  = 7'b0010010; segtab[3]  = 7'b0000110;
    segtab[4]  = 7'b1001100; segtab[5]  = 7'b0100100;
    segtab[6]  = 7'b0100000; segtab[7]  = 7'b0001111;
    segtab[8]  = 7'b0000000; segtab[9]  = 7'b0000100;
    segtab[10] = 7'b0000010; segtab[11] = 7'b1100000;
    segtab[12] = 7'b0110001; segtab[13] = 7'b1000010;
    segtab[14] = 7'b0110000; segtab[15] = 7'b0111000;
  end

  // Reference model: integer slot/frame bookkeeping over digit arrays
  int  m_cnt, m_idx, m_p;
  int  a_nib [4];
  int  s_nib [4];
  bit  a_dp [4];
  bit  a_bl [4];
  bit  s_dp [4];
  bit  s_bl [4];
  bit  m_pend;
  logic [3:0] e_an;
  logic [6:0] e_sg;
  logic       e_dp, e_fd;

  task automatic model_clock();
    bit tick, wrap, allz, dark;
    if (!rst) begin
      m_cnt = 0; m_idx = 0; m_p = 0; m_pend = 0;
      for (int j = 0; j < 4; j++) begin
        a_nib[j] = 0; s_nib[j] = 0; a_dp[j] = 0; a_bl[j] = 0; s_dp[j] = 0; s_bl[j] = 0;
      end
      e_an = 4'hF; e_sg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      return;
    end
    tick = en && (m_cnt >= int'(rate));
    wrap = tick && (m_idx == 3);
    allz = 1;
    for (int j = m_idx; j < 4; j++) if (a_nib[j] != 0) allz = 0;
    dark = !en || a_bl[m_idx] || (lz_en && m_idx != 0 && allz) ||
           !(bright == 4'hF || m_p < int'(bright));
    if (dark) begin
      e_an = 4'hF; e_sg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an = ~(4'b0001 << m_idx);
      e_sg = segtab[a_nib[m_idx]];
      e_dp = !a_dp[m_idx];
    end
    e_fd = wrap;
    if (en) begin
      m_cnt = tick ? 0 : m_cnt + 1;
      m_p   = (m_p + 1) % 16;
    end
    if (tick) m_idx = (m_idx + 1) % 4;
    if (load && wrap) begin
      for (int j = 0; j < 4; j++) begin
        a_nib[j] = int'(data_in[4*j +: 4]); a_dp[j] = dp_in[j]; a_bl[j] = blank_in[j];
      end
      m_pend = 0;
    end else begin
      if (wrap && m_pend) begin
        for (int j = 0; j < 4; j++) begin
          a_nib[j] = s_nib[j]; a_dp[j] = s_dp[j]; a_bl[j] = s_bl[j];
        end
        m_pend = 0;
      end
      if (load) begin
        for (int j = 0; j < 4; j++) begin
          s_nib[j] = int'(data_in[4*j +: 4]); s_dp[j] = dp_in[j]; s_bl[j] = blank_in[j];
        end
        m_pend = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {anode, seg, dp, frame_done};
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b0; load = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  // Static display configurations and the four digit outputs they must produce
  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpv;
    logic [3:0]  blank;
    logic        lz;
    logic [15:0] an;   // {d3,d2,d1,d0}
    logic [27:0] sg;   // {d3,d2,d1,d0}
    logic [3:0]  dpo;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int fdt [$];
    int cnt [4];
    int zeros;
    int lit_n;
    logic [3:0] an_hist [128];
    logic [12:0] exp_o;

    vecs[0] = '{16'h012A, 4'h0, 4'h0, 1'b0, 16'h7BDE,
                {7'b0000001, 7'b1001111, 7'b0010010, 7'b0000010}, 4'hF};
    vecs[1] = '{16'h0020, 4'h0, 4'h0, 1'b1, 16'hFFDE,
                {7'h7F, 7'h7F, 7'b0010010, 7'b0000001}, 4'hF};
    vecs[2] = '{16'h0020, 4'h0, 4'h1, 1'b1, 16'hFFDF,
                {7'h7F, 7'h7F, 7'b0010010, 7'h7F}, 4'hF};
    vecs[3] = '{16'h5555, 4'h5, 4'h0, 1'b0, 16'h7BDE,
                {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}, 4'hA};
    vecs[4] = '{16'h0000, 4'h0, 4'h0, 1'b1, 16'hFFFE,
                {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'hF};
    vecs[5] = '{16'hF8E0, 4'h0, 4'h0, 1'b1, 16'h7BDE,
                {7'b0111000, 7'b0000000, 7'b0110000, 7'b0000001}, 4'hF};
    vecs[6] = '{16'h9BCD, 4'h0, 4'h0, 1'b1, 16'h7BDE,
                {7'b0000100, 7'b1100000, 7'b0110001, 7'b1000010}, 4'hF};
    vecs[7] = '{16'h3467, 4'h0, 4'h0, 1'b0, 16'h7BDE,
                {7'b0000110, 7'b1001100, 7'b0100000, 7'b0001111}, 4'hF};
    vecs[8] = '{16'h0020, 4'h8, 4'h0, 1'b1, 16'hFFDE,
                {7'h7F, 7'h7F, 7'b0010010, 7'b0000001}, 4'hF};

    // Reset values after a long reset
    en = 1'b1; rate = 16'd0; bright = 4'hF;
    do_reset(10);
    rst = 1'b0;
    check("reset_anode", 0, 32'(anode), 32'hF);
    check("reset_seg", 0, 32'(seg), 32'h7F);
    check("reset_dp", 0, 32'(dp), 32'h1);
    check("reset_fd", 0, 32'(frame_done), 32'h0);

    // Table: load a frame, wait for it to take over, then check each digit slot
    for (int v = 0; v < 9; v++) begin
      do_reset(2);
      en = 1'b1; rate = 16'd0; bright = 4'hF;
      data_in = vecs[v].data; dp_in = vecs[v].dpv; blank_in = vecs[v].blank;
      lz_en = vecs[v].lz; load = 1'b1;
      step();
      load = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 4; k++) begin
        step();
        exp_o = {vecs[v].an[4*k +: 4], vecs[v].sg[7*k +: 7], vecs[v].dpo[k], (k == 3)};
        check("table", v*4 + k, 32'(outs()), 32'(exp_o));
      end
    end

    // Refresh rate 5: six cycles per slot, 24-cycle frame
    do_reset(2);
    en = 1'b1; rate = 16'd5; bright = 4'hF; lz_en = 1'b0;
    for (int t = 0; t < 80; t++) begin
      step();
      an_hist[t] = anode;
      if (frame_done) fdt.push_back(t);
    end
    check("fd_count", 0, 32'(fdt.size()), 32'd3);
    if (fdt.size() >= 3) begin
      check("fd_period", 0, 32'(fdt[1] - fdt[0]), 32'd24);
      check("fd_period", 1, 32'(fdt[2] - fdt[1]), 32'd24);
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      for (int t = fdt[0] + 1; t <= fdt[1]; t++)
        for (int k = 0; k < 4; k++)
          if (an_hist[t] == ~(4'b0001 << k)) cnt[k]++;
      for (int k = 0; k < 4; k++) check("slot_len", k, 32'(cnt[k]), 32'd6);
    end
    rate = 16'd0;

    // Tear-free load in mid-frame, then a load coincident with the wrap
    do_reset(2);
    en = 1'b1; rate = 16'd0; bright = 4'hF; lz_en = 1'b0;
    dp_in = '0; blank_in = '0; data_in = 16'h012A; load = 1'b1;
    step();
    load = 1'b0;
    repeat (8) step();                 // through digit 0 of 012A
    data_in = 16'h5555; load = 1'b1;   // during the digit-1 slot
    step();
    load = 1'b0; data_in = 16'h0000;
    step(); check("tf_old", 0, 32'(outs()), 32'({4'b1011, 7'b1001111, 1'b1, 1'b0}));
    step(); check("tf_old", 1, 32'(outs()), 32'({4'b0111, 7'b0000001, 1'b1, 1'b1}));
    step(); check("tf_new", 0, 32'(outs()), 32'({4'b1110, 7'b0100100, 1'b1, 1'b0}));
    step(); check("tf_new", 1, 32'(outs()), 32'({4'b1101, 7'b0100100, 1'b1, 1'b0}));
    step();
    data_in = 16'h89AB; load = 1'b1;   // digit-3 slot: wrap cycle
    step();
    load = 1'b0; data_in = 16'h0000;
    check("wrap_old", 0, 32'(outs()), 32'({4'b0111, 7'b0100100, 1'b1, 1'b1}));
    step(); check("wrap_new", 0, 32'(outs()), 32'({4'b1110, 7'b1100000, 1'b1, 1'b0}));
    step(); check("wrap_new", 1, 32'(outs()), 32'({4'b1101, 7'b0000010, 1'b1, 1'b0}));
    step(); check("wrap_new", 2, 32'(outs()), 32'({4'b1011, 7'b0000100, 1'b1, 1'b0}));
    step(); check("wrap_new", 3, 32'(outs()), 32'({4'b0111, 7'b0000000, 1'b1, 1'b1}));
    step(); check("wrap_hold", 0, 32'(outs()), 32'({4'b1110, 7'b1100000, 1'b1, 1'b0}));

    // Reset in the digit-2 slot, scan restarts at digit 0 showing zero
    do_reset(2);
    en = 1'b1; rate = 16'd0; data_in = 16'h012A; load = 1'b1;
    step();
    load = 1'b0;
    repeat (9) step();                 // next cycle is the digit-2 slot of 012A
    rst = 1'b0;
    step();
    check("midrst", 0, 32'(outs()), 32'({4'b1111, 7'h7F, 1'b1, 1'b0}));
    rst = 1'b1;
    step(); check("midrst", 1, 32'(outs()), 32'({4'b1110, 7'b0000001, 1'b1, 1'b0}));
    step(); check("midrst", 2, 32'(outs()), 32'({4'b1101, 7'b0000001, 1'b1, 1'b0}));

    // PWM at half duty: 16-cycle slots, each digit lit 8 cycles
    do_reset(2);
    en = 1'b1; rate = 16'd15; bright = 4'd8;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    zeros = 0;
    for (int t = 0; t < 64; t++) begin
      step();
      for (int k = 0; k < 4; k++) if (anode == ~(4'b0001 << k)) cnt[k]++;
      if (anode == 4'hF && seg != 7'h7F) zeros++;
    end
    for (int k = 0; k < 4; k++) check("pwm_half", k, 32'(cnt[k]), 32'd8);
    check("pwm_dark_seg", 0, 32'(zeros), 32'd0);
    bright = 4'd0; lit_n = 0;
    for (int t = 0; t < 32; t++) begin step(); if (anode != 4'hF) lit_n++; end
    check("pwm_zero", 0, 32'(lit_n), 32'd0);
    bright = 4'hF; lit_n = 0;
    step();
    for (int t = 0; t < 32; t++) begin step(); if (anode != 4'hF) lit_n++; end
    check("pwm_full", 0, 32'(lit_n), 32'd32);

    // Randomised traffic against the reference model
    do_reset(2);
    rate = 16'd1; bright = 4'hF; lz_en = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst  = ($urandom_range(0, 149) != 0);
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) rate = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 19) == 0)
        case ($urandom_range(0, 2))
          0: bright = 4'h0;
          1: bright = 4'hF;
          default: bright = 4'($urandom);
        endcase
      case ($urandom_range(0, 3))
        0: data_in = 16'($urandom);
        1: data_in = 16'($urandom) & 16'h00FF;
        2: data_in = 16'($urandom) & 16'h000F;
        default: data_in = 16'($urandom) & 16'h0F0F;
      endcase
      dp_in    = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step();
      check("rand", c, 32'(outs()), 32'({e_an, e_sg, e_dp, e_fd}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssd_scan_n.md
Name: ssd_scan_n

Overview:
- Parametrised multiplexed seven-segment display controller: next generation of the 4-digit ssd block.
- Scans DIGITS hex digits with programmable refresh rate, per-digit decimal point and blanking, and leading-zero suppression.
- Adds PWM brightness control and tear-free double-buffered data load with a frame-done strobe.
- Sits between the control-register backend and the board display pins.

Parameters:
- DIGITS, 4, number of digits/anodes (2..8).
- RATE_W, 16, width of refresh divider.
- BRIGHT_W, 4, width of brightness control.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- en  in  1  display enable; low blanks all outputs and holds counters.
- rate  in  RATE_W  slot length minus one, in clk cycles.
- data_in  in  4*DIGITS  hex nibbles; nibble k drives digit k (digit 0 = rightmost).
- dp_in  in  DIGITS  per-digit decimal point, 1 = lit.
- blank_in  in  DIGITS  per-digit force-blank.
- lz_en  in  1  leading-zero suppression enable.
- load  in  1  single-cycle strobe capturing data_in/dp_in/blank_in into the shadow buffer.
- bright  in  BRIGHT_W  brightness duty.
- anode  out  DIGITS  one-cold digit select, active-low.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset (rst=0 at posedge): anode all 1s, seg 7'b1111111, dp 1, frame_done 0; slot counter, digit index, PWM counter, active and shadow buffers, and pending flag cleared.
- Slot counter:
  - Increments each cycle while en=1.
  - When cnt >= rate: tick, and cnt returns to 0.
  - rate=0 gives a tick every cycle.
  - A rate reduced below the current cnt takes effect on the next cycle.
- Digit index: advances on tick. Wrapping DIGITS-1 -> 0 pulses frame_done on the same cycle as that tick.
- Double buffering:
  - load copies inputs to the shadow buffer and sets pending.
  - On wrap with pending=1, shadow copies to active and pending clears.
  - load on the same cycle as wrap: the new inputs go directly to active; pending stays 0.
  - load while pending: shadow is overwritten.
  - Before the first load, active = 0 with no blanking, so all digits show "0".
- Leading-zero suppression (lz_en=1): digit k is suppressed if its nibble and all higher nibbles are 0. Digit 0 is never suppressed.
- Digit dark when any of: blank_in bit set, suppressed, PWM off, or en=0. Dark means anode all 1s, seg 7'b1111111, dp 1.
- PWM:
  - Free-running BRIGHT_W counter p.
  - Digit lit when p < bright.
  - bright = all-ones means always lit; bright = 0 means always dark.
- Hex decode (active-low):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111.
  - 8 0000000, 9 0000100, A 0000010, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
- Latency: outputs are registered and reflect the digit index one cycle after the tick.
- dp output is the inverse of the active dp bit for the current digit.

Decomposition:
- Package ssd_pkg:
  - segment constants SEG_0..SEG_F and SEG_BLANK = 7'h7F.
  - default widths SSD_RATE_W and SSD_BRIGHT_W.
- Sub-module ssd_hex_dec: purely combinational 4-bit to 7-segment decoder. The top module holds all sequential logic.

Test Plan:
- Reset and dp:
  - Stimulus: hold rst=0 for 10 cycles.
  - Response: anode=4'b1111, seg=7'h7F, dp=1, frame_done=0.
- Basic scan:
  - Stimulus: rate=0, bright=4'hF, en=1, load 16'h012A with lz_en=0.
  - Response: successive cycles show anode 1110/seg 0000010, 1101/0010010, 1011/1001111, 0111/0000001. frame_done pulses once every 4 cycles.
- Refresh rate:
  - Stimulus: rate=5.
  - Response: each anode pattern is held exactly 6 cycles; frame_done period is 24 cycles.
- Leading-zero suppression and blanking:
  - Stimulus: lz_en=1, data 16'h0020.
  - Response: digit 3 slot shows anode 1111. Digit 2 slot is also blank (nibble 0, higher nibble zero). Digit 1 shows 0010010. Digit 0 shows 0000001. blank_in=4'b0001 then darkens digit 0 as well.
- Tear-free load:
  - Stimulus: pulse load with 16'h5555 during the digit-1 slot.
  - Response: remaining slots still show the old data; new data appears from the first slot after frame_done. Repeat with load coincident with wrap: new data shows in the immediately following slot.
- PWM and reset mid-scan:
  - Stimulus: bright=8 with BRIGHT_W=4.
  - Response: each digit is lit 8 of every 16 cycles.
  - Stimulus: assert rst during the digit-2 slot.
  - Response: next cycle outputs are at reset values, and the scan restarts at digit 0 with data 0 after release.
